// File: rtl/rc5_pkg.sv
// rc5_pkg: shared state encoding, sizing helpers and magic constants for the RC5/RC6 key schedule.
package rc5_pkg;
  typedef enum logic [1:0] {IDLE, INIT_S, MIX, DONE} state_e;
  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;
  function automatic int t_words(input int r, input int rc6);
    return rc6 != 0 ? 2 * r + 4 : 2 * (r + 1);
  endfunction
  function automatic int c_words(input int b, input int w);
    return (b + w / 8 - 1) / (w / 8);
  endfunction
  function automatic int n_iters(input int t, input int c);
    return 3 * (t > c ? t : c);
  endfunction
  function automatic int addr_len(input int x);
    return $clog2(x) < 1 ? 1 : $clog2(x);
  endfunction
endpackage

// File: rtl/rc5_key_schedule_if.sv
// rc5_key_schedule_if: key load, start/status and S-table read port of the key schedule.
interface rc5_key_schedule_if #(
  parameter int W = 32,
  parameter int T_LEN = 5,
  parameter int B_LEN = 4
);
  logic start;
  logic key_we;
  logic [B_LEN-1:0] key_addr;
  logic [7:0] key_byte;
  logic [T_LEN-1:0] s_rd_addr;
  logic [W-1:0] s_rd_data;
  logic busy;
  logic done;
  modport master(output start, key_we, key_addr, key_byte, s_rd_addr, input s_rd_data, busy, done);
  modport slave(input start, key_we, key_addr, key_byte, s_rd_addr, output s_rd_data, busy, done);
endinterface

// File: rtl/rc5_rotl.sv
// rc5_rotl: combinational variable left-rotate of a W-bit word.
module rc5_rotl #(
  parameter int W = 32
) (
  input  logic [W-1:0] data,
  input  logic [$clog2(W)-1:0] amount,
  output logic [W-1:0] result
);
  // a shift by W yields zero, so amount 0 degenerates cleanly to data
  assign result = (data << amount) | (data >> (W - int'(amount)));
endmodule

// File: rtl/rc5_key_schedule.sv
// rc5_key_schedule: RC5/RC6 key expansion (key load, P/Q fill, 3*max(T,C) mix) with a registered S read port.
module rc5_key_schedule
  import rc5_pkg::*;
#(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16,
  parameter int RC6 = 0,
  parameter logic [W-1:0] P_W = W'(P32),
  parameter logic [W-1:0] Q_W = W'(Q32)
) (
  input logic clk1,
  input logic rst,
  rc5_key_schedule_if.slave bus
);
  localparam int T = t_words(R, RC6);
  localparam int U = W / 8;
  localparam int C = c_words(B, W);
  localparam int N = n_iters(T, C);
  localparam int T_LEN = addr_len(T);
  localparam int C_LEN = addr_len(C);
  localparam int N_LEN = addr_len(N);
  localparam int B_LEN = addr_len(B);
  localparam int SH = $clog2(W);
  state_e state_q;
  logic [W-1:0] s_q [T];
  logic [W-1:0] l_q [C];
  logic [W-1:0] a_q, b_q, pq_q, rd_q;
  logic [T_LEN-1:0] i_q;
  logic [C_LEN-1:0] j_q;
  logic [N_LEN-1:0] n_q;
  logic busy_q, done_q;
  logic [W-1:0] a_d, b_d;
  logic go;
  assign go = bus.start && (state_q == IDLE || state_q == DONE);
  rc5_rotl #(.W(W)) u_rot_a (.data(s_q[i_q] + a_q + b_q), .amount(SH'(3)), .result(a_d));
  rc5_rotl #(.W(W)) u_rot_b (.data(l_q[j_q] + a_d + b_q), .amount(SH'(a_d + b_q)), .result(b_d));
  assign bus.s_rd_data = rd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // busy/done trail the state by one edge; i doubles as the fill index k during INIT_S
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      pq_q <= '0;
      rd_q <= '0;
      i_q <= '0;
      j_q <= '0;
      n_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int x = 0; x < T; x++) s_q[x] <= '0;
      for (int x = 0; x < C; x++) l_q[x] <= '0;
    end else begin
      rd_q <= (int'(bus.s_rd_addr) < T) ? s_q[bus.s_rd_addr] : '0;
      busy_q <= state_q == INIT_S || state_q == MIX;
      done_q <= state_q == DONE && !go;
      if (bus.key_we && !busy_q)
        for (int x = 0; x < C; x++)
          for (int y = 0; y < U; y++)
            if (x * U + y < B && bus.key_addr == B_LEN'(x * U + y)) l_q[x][8*y +: 8] <= bus.key_byte;
      if (go) begin
        state_q <= INIT_S;
        i_q <= '0;
        pq_q <= P_W;
        a_q <= '0;
        b_q <= '0;
      end else if (state_q == INIT_S) begin
        s_q[i_q] <= pq_q;
        pq_q <= pq_q + Q_W;
        i_q <= (i_q == T_LEN'(T - 1)) ? '0 : i_q + T_LEN'(1);
        if (i_q == T_LEN'(T - 1)) begin
          state_q <= MIX;
          j_q <= '0;
          n_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end
      end else if (state_q == MIX) begin
        s_q[i_q] <= a_d;
        l_q[j_q] <= b_d;
        a_q <= a_d;
        b_q <= b_d;
        i_q <= (i_q == T_LEN'(T - 1)) ? '0 : i_q + T_LEN'(1);
        j_q <= (j_q == C_LEN'(C - 1)) ? '0 : j_q + C_LEN'(1);
        n_q <= n_q + N_LEN'(1);
        if (n_q == N_LEN'(N - 1)) state_q <= DONE;
      end
    end
endmodule

// File: tb/tb_rc5_key_schedule.sv
// tb_rc5_key_schedule: scoreboard bench for the RC5 key schedule against a behavioural key-expansion model.
module tb_rc5_key_schedule;
  localparam int TN = 104;
  localparam int TN16 = 80;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  rc5_key_schedule_if #(.W(32), .T_LEN(5), .B_LEN(4)) if_a ();
  rc5_key_schedule_if #(.W(16), .T_LEN(5), .B_LEN(3)) if_b ();
  rc5_key_schedule dut (.clk1(clk), .rst(rst_n), .bus(if_a));
  rc5_key_schedule #(.W(16), .R(8), .B(5), .RC6(1), .P_W(16'hB7E1), .Q_W(16'h9E37))
    dut16 (.clk1(clk), .rst(rst_n), .bus(if_b));
  longint unsigned exp_zero[32], exp3[32], exp16[32];
  byte unsigned kz[16], k3[16], k16[16];
  logic [63:0] sbq[$];
  logic [63:0] exp_v;
  int passed = 0, total = 0;
  int cnt, bad;

  function automatic longint unsigned rotl(input longint unsigned x, input int r, input int w, input longint unsigned m);
    int s = r % w;
    return s == 0 ? (x & m) : (((x & m) << s) | ((x & m) >> (w - s))) & m;
  endfunction

  function automatic void model(input int w, input int t, input int b, input byte unsigned key[16],
                                input longint unsigned p, input longint unsigned q, output longint unsigned s[32]);
    int u, c, i, j;
    longint unsigned m, a, bb;
    longint unsigned l[16];
    u = w / 8;
    c = (b + u - 1) / u;
    m = (w == 64) ? '1 : (64'd1 << w) - 1;
    for (int k = 0; k < 16; k++) l[k] = 0;
    for (int k = 0; k < 32; k++) s[k] = 0;
    for (int k = b - 1; k >= 0; k--) l[k/u] = ((l[k/u] << 8) + key[k]) & m;
    s[0] = p & m;
    for (int k = 1; k < t; k++) s[k] = (s[k-1] + q) & m;
    a = 0; bb = 0; i = 0; j = 0;
    for (int k = 0; k < 3 * (t > c ? t : c); k++) begin
      a = rotl(s[i] + a + bb, 3, w, m);
      s[i] = a;
      bb = rotl(l[j] + a + bb, int'((a + bb) & 64'd63), w, m);
      l[j] = bb;
      i = (i + 1) % t;
      j = (j + 1) % c;
    end
  endfunction

  task automatic write_key(input int addr, input logic [7:0] v);
    if_a.key_we = 1'b1; if_a.key_addr = 4'(addr); if_a.key_byte = v;
    @(posedge clk); #1;
    if_a.key_we = 1'b0;
  endtask

  task automatic issue_read(input int k, input longint unsigned e);
    if_a.s_rd_addr = 5'(k);
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run(input bit key0, input bit inject, output int c, output int b);
    c = 0; b = 0;
    if_a.start = 1'b1;
    if (key0) begin if_a.key_we = 1'b1; if_a.key_addr = '0; if_a.key_byte = 8'h00; end
    @(posedge clk); #1;
    if_a.start = 1'b0; if_a.key_we = 1'b0;
    if (if_a.busy !== 1'b0) b++;
    while (if_a.done !== 1'b1 && c < 400) begin
      if (inject && c == 40) begin
        if_a.start = 1'b1; if_a.key_we = 1'b1; if_a.key_addr = '0; if_a.key_byte = 8'hFF;
      end
      @(posedge clk); #1; c++;
      if_a.start = 1'b0; if_a.key_we = 1'b0;
      if (if_a.busy !== (c <= TN)) b++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if_a.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", if_a.busy); else passed++;
    total++; if (if_a.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", if_a.done); else passed++;
    total++; if (if_a.s_rd_data !== 32'h0) $display("FAIL reset_rd: got %h expected 0", if_a.s_rd_data); else passed++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (if_a.done !== 1'b0 || if_a.busy !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", if_a.busy, if_a.done); else passed++;
  endtask

  task automatic test_init_mix();
    int c = 0;
    if_a.s_rd_addr = 5'd1;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    while (if_a.done !== 1'b1 && c < 400) begin
      @(posedge clk); #1; c++;
      if (c == 26) begin
        total++; if (if_a.s_rd_data !== 32'h5618CB1C) $display("FAIL init_s1: got %h expected 5618cb1c", if_a.s_rd_data); else passed++;
        if_a.s_rd_addr = 5'd0;
      end else if (c == 27) begin
        total++; if (if_a.s_rd_data !== 32'hB7E15163) $display("FAIL init_s0: got %h expected b7e15163", if_a.s_rd_data); else passed++;
      end else if (c == 28) begin
        total++; if (if_a.s_rd_data !== 32'hBF0A8B1D) $display("FAIL mix1_s0: got %h expected bf0a8b1d", if_a.s_rd_data); else passed++;
      end
    end
    total++; if (c !== TN + 1) $display("FAIL zero_done_edge: got %0d expected %0d", c, TN + 1); else passed++;
    for (int k = 0; k < 26; k++) begin
      issue_read(k, exp_zero[k]);
      exp_v = sbq.pop_front();
      total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL zero_S%0d: got %h expected %h", k, if_a.s_rd_data, exp_v[31:0]); else passed++;
    end
  endtask

  task automatic test_key_load();
    for (int k = 0; k < 16; k++) write_key(k, 8'(k));
    run(1'b0, 1'b0, cnt, bad);
    total++; if (cnt !== TN + 1) $display("FAIL key_done_edge: got %0d expected %0d", cnt, TN + 1); else passed++;
    total++; if (bad !== 0) $display("FAIL key_busy_window: got %0d bad cycles expected 0", bad); else passed++;
    for (int k = 0; k < 26; k++) begin
      issue_read(k, exp3[k]);
      exp_v = sbq.pop_front();
      total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL key_S%0d: got %h expected %h", k, if_a.s_rd_data, exp_v[31:0]); else passed++;
    end
    if_a.s_rd_addr = 5'd5;
    sbq.push_back(exp3[5]);
    #1;
    total++; if (if_a.s_rd_data !== exp3[25][31:0]) $display("FAIL rd_latency_hold: got %h expected %h", if_a.s_rd_data, exp3[25][31:0]); else passed++;
    @(posedge clk); #1;
    exp_v = sbq.pop_front();
    total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL rd_latency_s5: got %h expected %h", if_a.s_rd_data, exp_v[31:0]); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k < 16; k++) write_key(k, 8'(k));
    run(1'b1, 1'b1, cnt, bad);
    total++; if (cnt !== TN + 1) $display("FAIL b2b_done_edge: got %0d expected %0d", cnt, TN + 1); else passed++;
    total++; if (bad !== 0) $display("FAIL b2b_busy_window: got %0d bad cycles expected 0", bad); else passed++;
    for (int k = 0; k < 26; k++) begin
      issue_read(k, exp3[k]);
      exp_v = sbq.pop_front();
      total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL b2b_S%0d: got %h expected %h", k, if_a.s_rd_data, exp_v[31:0]); else passed++;
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 16; k++) write_key(k, 8'(k));
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    for (int k = 0; k < 56; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (if_a.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", if_a.busy); else passed++;
    total++; if (if_a.done !== 1'b0) $display("FAIL abort_done: got %b expected 0", if_a.done); else passed++;
    total++; if (if_a.s_rd_data !== 32'h0) $display("FAIL abort_rd: got %h expected 0", if_a.s_rd_data); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if_a.done !== 1'b0) $display("FAIL abort_done_stays_low: got %b expected 0", if_a.done); else passed++;
    issue_read(3, 64'h0);
    exp_v = sbq.pop_front();
    total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL abort_s3_cleared: got %h expected %h", if_a.s_rd_data, exp_v[31:0]); else passed++;
    for (int k = 0; k < 16; k++) write_key(k, 8'(k));
    run(1'b0, 1'b0, cnt, bad);
    total++; if (cnt !== TN + 1) $display("FAIL rerun_done_edge: got %0d expected %0d", cnt, TN + 1); else passed++;
    for (int k = 0; k < 26; k++) begin
      issue_read(k, exp3[k]);
      exp_v = sbq.pop_front();
      total++; if ({32'b0, if_a.s_rd_data} !== exp_v) $display("FAIL rerun_S%0d: got %h expected %h", k, if_a.s_rd_data, exp_v[31:0]); else passed++;
    end
  endtask

  task automatic test_w16();
    int c = 0;
    for (int k = 0; k < 8; k++) begin
      if_b.key_we = 1'b1; if_b.key_addr = 3'(k); if_b.key_byte = (k < 5) ? k16[k] : 8'hAA;
      @(posedge clk); #1;
    end
    if_b.key_we = 1'b0;
    if_b.s_rd_addr = 5'd1;
    if_b.start = 1'b1;
    @(posedge clk); #1;
    if_b.start = 1'b0;
    while (if_b.done !== 1'b1 && c < 400) begin
      @(posedge clk); #1; c++;
      if (c == 20) begin
        total++; if (if_b.s_rd_data !== 16'h5618) $display("FAIL w16_init_s1: got %h expected 5618", if_b.s_rd_data); else passed++;
      end
    end
    total++; if (c !== TN16 + 1) $display("FAIL w16_done_edge: got %0d expected %0d", c, TN16 + 1); else passed++;
    for (int k = 0; k < 20; k++) begin
      if_b.s_rd_addr = 5'(k);
      sbq.push_back(exp16[k]);
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      total++; if ({48'b0, if_b.s_rd_data} !== exp_v) $display("FAIL w16_S%0d: got %h expected %h", k, if_b.s_rd_data, exp_v[15:0]); else passed++;
    end
  endtask

  initial begin
    {if_a.start, if_a.key_we, if_a.key_addr, if_a.key_byte, if_a.s_rd_addr} = '0;
    {if_b.start, if_b.key_we, if_b.key_addr, if_b.key_byte, if_b.s_rd_addr} = '0;
    for (int k = 0; k < 16; k++) begin
      kz[k] = 8'h00;
      k3[k] = 8'(k);
      k16[k] = (k < 5) ? 8'(8'h11 * (k + 1)) : 8'h00;
    end
    model(32, 26, 16, kz, 64'hB7E15163, 64'h9E3779B9, exp_zero);
    model(32, 26, 16, k3, 64'hB7E15163, 64'h9E3779B9, exp3);
    model(16, 20, 5, k16, 64'hB7E1, 64'h9E37, exp16);
    test_reset();
    test_init_mix();
    test_key_load();
    test_back_to_back();
    test_abort();
    test_w16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rc5_key_schedule.md
Name: rc5_key_schedule

Overview:
Parametrised successor to the S-array initialiser. It performs the complete RC5/RC6 key expansion in one block: it loads key bytes into L, fills S with the P/Q progression, runs the 3*max(T,C) mixing pass, and exposes the finished S table through a registered read port. The encryption/decryption datapath reads round keys from this block once done is high.

Parameters:
W, 32, word width in bits; legal values 16, 32, 64.
R, 12, number of rounds.
B, 16, key length in bytes; must be at least 1.
RC6, 0, S-table sizing: 0 gives T=2*(R+1) (RC5); 1 gives T=2*R+4 (RC6).
P_W, 32'hB7E15163, magic constant P truncated to W bits.
Q_W, 32'h9E3779B9, magic constant Q truncated to W bits.
Derived, not overridable:
- U=W/8.
- C=ceil(B/U).
- N=3*max(T,C).
- T_LEN=$clog2(T), C_LEN=max(1,$clog2(C)), B_LEN=max(1,$clog2(B)).

Ports:
clk1  in  1  single system clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-low.
start  in  1  one-cycle request to run the expansion.
key_we  in  1  key byte write strobe.
key_addr  in  B_LEN  key byte index, 0..B-1.
key_byte  in  8  key byte data.
s_rd_addr  in  T_LEN  S table read index.
s_rd_data  out  W  S[s_rd_addr], registered, 1-cycle latency.
busy  out  1  high during INIT_S and MIX.
done  out  1  level; high when the S table is valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, s_rd_data=0.
  - All S[], L[], A, B, i, j and counters are cleared to 0.
  - Reset mid-run aborts immediately. After release, done stays 0 until a new start.
- Key load:
  - key_we with !busy writes L[key_addr/U] byte lane (key_addr%U), little-endian, as in RC5.
  - key_addr >= B is ignored.
  - key_we while busy is ignored.
  - L keeps its value across runs; unwritten bytes stay 0.
- States:
  - IDLE: start=1 goes to INIT_S; clear k, done, A, B.
  - INIT_S: one word per cycle. S[k] <= P_W + k*Q_W mod 2^W, computed as a running sum (S[0]=P_W). After k=T-1, go to MIX with i=j=n=0, A=B=0.
  - MIX: one iteration per cycle.
    - A' = rotl(S[i]+A+B, 3); S[i] <= A'.
    - B' = rotl(L[j]+A'+B, (A'+B) mod W); L[j] <= B'.
    - A <= A', B <= B'.
    - i wraps at T, j wraps at C.
    - After n=N-1, go to DONE.
  - DONE: done=1, busy=0. start returns to INIT_S and done drops on that same edge.
- All additions are modulo 2^W. The rotate amount uses the low $clog2(W) bits of A'+B.
- Timing: start sampled at edge e. busy=1 from edge e+1 through e+T+N. done=1 at edge e+T+N+1 (W=32, R=12, B=16: T+N=26+78=104).
- start while busy is ignored. start and key_we in the same idle cycle: the key write happens first, and INIT_S begins on the same edge.
- s_rd_data is updated every cycle from the current S contents; it is only meaningful while done=1.
- L is overwritten by the mix. Reloading the key is required before re-running with the original key.

Decomposition:
- Package rc5_pkg holds:
  - the state enum (IDLE, INIT_S, MIX, DONE);
  - functions for T, C, N and the address widths;
  - magic constants P16/Q16, P32/Q32, P64/Q64.
- One sub-module: rc5_rotl, a combinational variable left-rotate, parameter W, inputs data[W] and amount[$clog2(W)].

Test Plan:
1. Defaults, zero key: start → after 26 INIT cycles (sampled before MIX), S[0]=0xB7E15163, S[1]=0x5618CB1C.
2. Zero key, first MIX iteration: A=0xBF0A8B1D, S[0]=0xBF0A8B1D, L[0]=0xB7E15163. done rises exactly 105 edges after the start edge. Every S[0..25] matches the C reference model dump.
3. Key bytes 0x00..0x0F written, then start → S table equals the C model. s_rd_addr=5 returns S[5] one cycle later.
4. start, then at busy cycle 40 assert start and key_we (addr 0, 0xFF) → both ignored. The completion edge is unchanged and the results equal scenario 3.
5. rst=0 at MIX cycle 30 → busy=0, done=0, s_rd_data=0 immediately. A new start after key reload reproduces scenario 3.
6. W=16, R=8, B=5, RC6=1 (T=20, C=3, N=60), P=0xB7E1, Q=0x9E37 → S[1]=0x5618; done at start+81; full table matches the model.
